// File: rtl/cpu_pkg.sv
// Shared types for the hazard unit: forward-select encoding, pipeline shadow slot, XZR.
package cpu_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned STAT_W = 16;

  localparam logic [REG_W-1:0] XZR = REG_W'(31);

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             setflags;
  } slot_t;

  // True when the slot will write architectural register r (XZR never matches).
  function automatic logic writes_reg(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != XZR);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One shadow pipeline slot: captures d each cycle, or a bubble when bubble=1.
module pipe_slot
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  slot_t slot_d, slot_q;

  always_comb begin
    slot_d = d;
    if (bubble) slot_d.valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign q = slot_q;

endmodule

// File: rtl/hazard_unit.sv
// Load-use / flag stall, branch flush and EX/MEM forwarding selects for a 5-stage core.
// Define HAZARD_STATS_EN to add saturating stall_count / fwd_count outputs.
module hazard_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_Rn,
  input  logic [4:0] id_Rm,
  input  logic       id_uses_Rm,
  input  logic       id_uses_flags,
  input  logic [4:0] id_Rd,
  input  logic       id_RegWrite,
  input  logic       id_MemRead,
  input  logic       id_setflags,
  input  logic       br_taken,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB,
`ifdef HAZARD_STATS_EN
  output logic [15:0] stall_count,
  output logic [15:0] fwd_count,
`endif
  output logic       stall,
  output logic       flush
);

  slot_t    id_slot, ex_q, mem_q, wb_q;
  fwd_sel_t fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
  logic     load_use, flag_haz, ex_bubble;

  always_comb begin
    id_slot           = '0;
    id_slot.valid     = 1'b1;
    id_slot.rd        = id_Rd;
    id_slot.reg_write = id_RegWrite;
    id_slot.mem_read  = id_MemRead;
    id_slot.setflags  = id_setflags;
  end

  // Older slots always advance; only EX takes a bubble on stall or flush.
  pipe_slot u_ex  (.clk(clk), .reset(reset), .bubble(ex_bubble), .d(id_slot), .q(ex_q));
  pipe_slot u_mem (.clk(clk), .reset(reset), .bubble(1'b0),      .d(ex_q),    .q(mem_q));
  pipe_slot u_wb  (.clk(clk), .reset(reset), .bubble(1'b0),      .d(mem_q),   .q(wb_q));

  always_comb begin
    load_use  = ex_q.mem_read &&
                (writes_reg(ex_q, id_Rn) || (id_uses_Rm && writes_reg(ex_q, id_Rm)));
    flag_haz  = id_uses_flags && ex_q.valid && ex_q.setflags;
    flush     = br_taken;
    stall     = (load_use || flag_haz) && !br_taken;
    ex_bubble = stall || flush;
  end

  // Newer producer (EX) wins over MEM; selects are consumed in the next (EX) cycle.
  always_comb begin
    fwd_a_d = FWD_REG;
    fwd_b_d = FWD_REG;
    if (!ex_bubble) begin
      if (writes_reg(ex_q, id_Rn) && !ex_q.mem_read) fwd_a_d = FWD_MEM;
      else if (writes_reg(mem_q, id_Rn))             fwd_a_d = FWD_WB;
      if (id_uses_Rm) begin
        if (writes_reg(ex_q, id_Rm) && !ex_q.mem_read) fwd_b_d = FWD_MEM;
        else if (writes_reg(mem_q, id_Rm))             fwd_b_d = FWD_WB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign forwardA = fwd_a_q;
  assign forwardB = fwd_b_q;

  // WB slot and some MEM fields are bookkeeping only; nothing reads them here.
  logic unused_bits;
  assign unused_bits = ^{wb_q, mem_q.mem_read, mem_q.setflags};

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_d, stall_cnt_q, fwd_cnt_d, fwd_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STAT_W'(1);
    if (((fwd_a_q != FWD_REG) || (fwd_b_q != FWD_REG)) && (fwd_cnt_q != '1))
      fwd_cnt_d = fwd_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign fwd_count   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: an instruction-stream table plus hand sequences.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_Rn, id_Rm, id_Rd;
  logic       id_uses_Rm, id_uses_flags, id_RegWrite, id_MemRead, id_setflags, br_taken;
  logic [1:0] forwardA, forwardB;
  logic       stall, flush;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count, fwd_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .id_Rn(id_Rn), .id_Rm(id_Rm), .id_uses_Rm(id_uses_Rm), .id_uses_flags(id_uses_flags),
    .id_Rd(id_Rd), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_setflags(id_setflags), .br_taken(br_taken),
    .forwardA(forwardA), .forwardB(forwardB),
`ifdef HAZARD_STATS_EN
    .stall_count(stall_count), .fwd_count(fwd_count),
`endif
    .stall(stall), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rn, rm;
    logic       uses_rm, uses_flags;
    logic [4:0] rd;
    logic       rw, mr, sf, br;
    logic       exp_stall, exp_flush;
    logic [1:0] exp_a, exp_b;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_Rn = v.rn; id_Rm = v.rm; id_uses_Rm = v.uses_rm; id_uses_flags = v.uses_flags;
    id_Rd = v.rd; id_RegWrite = v.rw; id_MemRead = v.mr; id_setflags = v.sf;
    br_taken = v.br;
  endtask

  // Drive one ID instruction, let it pass one clock edge, no checks.
  task automatic issue(input vec_t v);
    drive(v);
    @(posedge clk); #1;
  endtask

  vec_t v;

  initial begin
    //          rn  rm  uRm uFl rd  rw mr sf br   stall flush fA fB
    vecs[0]  = '{ 0,  0, 0, 0,  1, 1, 0, 0, 0,   0, 0, 0, 0}; // ADD X1
    vecs[1]  = '{ 1,  0, 0, 0,  9, 1, 0, 0, 0,   0, 0, 1, 0}; // EX->ID on Rn
    vecs[2]  = '{ 0,  0, 0, 0,  2, 1, 0, 0, 0,   0, 0, 0, 0}; // ADD X2
    vecs[3]  = '{ 0,  0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0}; // NOP
    vecs[4]  = '{ 0,  2, 1, 0,  0, 0, 0, 0, 0,   0, 0, 0, 2}; // MEM->ID on Rm
    vecs[5]  = '{ 0,  0, 0, 0,  3, 1, 1, 0, 0,   0, 0, 0, 0}; // LDUR X3
    vecs[6]  = '{ 3,  0, 0, 0,  4, 1, 0, 0, 0,   1, 0, 0, 0}; // load-use stall
    vecs[7]  = '{ 3,  0, 0, 0,  4, 1, 0, 0, 0,   0, 0, 2, 0}; // replay -> from WB
    vecs[8]  = '{ 0,  0, 0, 0, 31, 1, 0, 0, 0,   0, 0, 0, 0}; // ADD X31
    vecs[9]  = '{31, 31, 1, 0,  5, 1, 0, 0, 0,   0, 0, 0, 0}; // XZR never forwards
    vecs[10] = '{31, 31, 1, 0,  5, 1, 0, 0, 0,   0, 0, 0, 0}; // XZR in MEM
    vecs[11] = '{ 5,  5, 1, 0,  0, 0, 0, 0, 0,   0, 0, 1, 1}; // X5 in EX and MEM: EX wins
    vecs[12] = '{ 0,  5, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0}; // uses_Rm=0 gates B
    vecs[13] = '{ 0,  0, 0, 0,  6, 1, 0, 1, 0,   0, 0, 0, 0}; // SUBS X6
    vecs[14] = '{ 0,  0, 0, 1,  0, 0, 0, 0, 0,   1, 0, 0, 0}; // B.cond flag stall
    vecs[15] = '{ 0,  0, 0, 1,  0, 0, 0, 0, 0,   0, 0, 0, 0}; // replay: stall released
    vecs[16] = '{ 0,  0, 0, 0,  7, 1, 0, 0, 0,   0, 0, 0, 0}; // ADD X7
    vecs[17] = '{ 7,  0, 0, 0,  0, 0, 0, 0, 1,   0, 1, 0, 0}; // flush kills forward
    vecs[18] = '{ 7,  0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 2, 0}; // X7 still reached MEM
    vecs[19] = '{ 0,  0, 0, 0, 10, 1, 1, 0, 0,   0, 0, 0, 0}; // LDUR X10
    vecs[20] = '{ 0, 10, 1, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0}; // load-use on Rm
    vecs[21] = '{ 0, 10, 1, 0,  0, 0, 0, 0, 0,   0, 0, 0, 2}; // replay -> from WB

    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(v);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset fwdA", 16'(forwardA), 16'd0);
    check("reset fwdB", 16'(forwardB), 16'd0);
`ifdef HAZARD_STATS_EN
    check("reset stall_count", stall_count, 16'd0);
    check("reset fwd_count", fwd_count, 16'd0);
`endif
    reset = 1'b0;
    #1;
    check("reset stall", 16'(stall), 16'd0);
    check("reset flush", 16'(flush), 16'd0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d stall", i), 16'(stall), 16'(vecs[i].exp_stall));
      check($sformatf("v%0d flush", i), 16'(flush), 16'(vecs[i].exp_flush));
      @(posedge clk); #1;
      check($sformatf("v%0d fwdA", i), 16'(forwardA), 16'(vecs[i].exp_a));
      check($sformatf("v%0d fwdB", i), 16'(forwardB), 16'(vecs[i].exp_b));
    end

    // Flag stall, then a taken branch in the same cycle overrides it.
    issue('{0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 0, 0, 0});          // SUBS X6
    drive('{6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});          // B.cond
    #1;
    check("flag stall", 16'(stall), 16'd1);
    check("flag flush pre", 16'(flush), 16'd0);
    br_taken = 1'b1;
    #1;
    check("flush over stall", 16'(stall), 16'd0);
    check("flush follows br", 16'(flush), 16'd1);
    @(posedge clk); #1;
    check("flush fwdA", 16'(forwardA), 16'd0);
    check("flush fwdB", 16'(forwardB), 16'd0);
    drive('{6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #1;
    check("post flush stall", 16'(stall), 16'd0);
    @(posedge clk); #1;
    check("post flush fwdA", 16'(forwardA), 16'd2);

    // Reset while a load-use stall is pending.
    issue('{0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0});          // LDUR X3
    drive('{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #1;
    check("pre-reset stall", 16'(stall), 16'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid-stall reset fwdA", 16'(forwardA), 16'd0);
`ifdef HAZARD_STATS_EN
    check("mid-stall reset stall_count", stall_count, 16'd0);
    check("mid-stall reset fwd_count", fwd_count, 16'd0);
`endif
    reset = 1'b0;
    #1;
    check("after reset stall", 16'(stall), 16'd0);
    @(posedge clk); #1;
    check("after reset fwdA", 16'(forwardA), 16'd0);
    check("after reset fwdB", 16'(forwardB), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports id_Rn, input, 5 bits and id_Rm, input, 5 bits: source registers of the instruction in ID.
REQ-004 SHALL have ports id_uses_Rm, input, 1 bit and id_uses_flags, input, 1 bit: the ID instruction reads Rm, or reads the flags (B.cond).
REQ-005 SHALL have port id_Rd, input, 5 bits: destination register of the ID instruction.
REQ-006 SHALL have ports id_RegWrite, id_MemRead and id_setflags, inputs, 1 bit each: ID control bits.
REQ-007 SHALL have port br_taken, input, 1 bit: branch resolved taken this cycle.
REQ-008 SHALL have ports forwardA, output, 2 bits and forwardB, output, 2 bits: registered selects for the EX-stage operand muxes.
REQ-009 SHALL have port stall, output, 1 bit: combinational; holds PC and IF/ID.
REQ-010 SHALL have port flush, output, 1 bit: combinational; squashes IF/ID.

Function
REQ-011 Forward select encoding SHALL be 00 = register-file value, 01 = alu_result_mem, 10 = alu_result_wb; 11 SHALL never be driven.
REQ-012 The unit SHALL keep shadow slots EX, MEM and WB, each holding {valid, Rd, RegWrite, MemRead, setflags}.
REQ-013 When neither stall nor flush is active, the slots SHALL advance every cycle: ID controls go into EX, EX into MEM, MEM into WB.
REQ-014 A slot "writes r" only when valid=1, RegWrite=1, Rd=r and r != 31; X31 (XZR) SHALL never match.
REQ-015 Load-use: stall SHALL be 1 when the EX slot has MemRead=1 and writes id_Rn, or writes id_Rm while id_uses_Rm=1.
REQ-016 Flag hazard: stall SHALL be 1 when id_uses_flags=1 and the EX slot is valid with setflags=1.
REQ-017 When stall=1, the EX slot SHALL load a bubble (valid=0), MEM and WB SHALL still advance, and forwardA/B SHALL load 00.
REQ-018 Every stall SHALL last exactly one cycle for a single hazard, because the producer leaves EX.
REQ-019 The next forwardA SHALL be 01 if the current EX slot (not a load) writes id_Rn, else 10 if the current MEM slot writes id_Rn, else 00.
REQ-020 forwardB SHALL follow the same rule on id_Rm, gated by id_uses_Rm; when id_uses_Rm=0 it SHALL be 00.
REQ-021 The newer producer SHALL win: an EX-slot match SHALL take priority over a MEM-slot match.
REQ-022 flush SHALL equal br_taken in the same cycle.
REQ-023 flush SHALL take priority over stall: stall SHALL read 0 while br_taken=1.
REQ-024 On flush, the EX slot SHALL load a bubble and forwardA/B SHALL load 00.
REQ-025 Forward latency SHALL be one cycle: selects computed in ID SHALL be valid throughout the following EX cycle.

Reset
REQ-026 When reset=1 at a clock edge, all slot valid bits SHALL clear and forwardA/B SHALL become 00.
REQ-027 While the slots are invalid, stall SHALL be 0; flush SHALL still follow br_taken.
REQ-028 Reset asserted mid-stall SHALL drop the pending hazard, so stall=0 in the cycle after reset.

Configuration
REQ-029 With HAZARD_STATS_EN defined, the module SHALL add two outputs, 16 bits each: stall_count and fwd_count.
REQ-030 With HAZARD_STATS_EN, stall_count SHALL increment on every cycle with stall=1, saturate at 0xFFFF, and clear on reset.
REQ-031 With HAZARD_STATS_EN, fwd_count SHALL increment on every cycle in which either registered select is nonzero, saturate at 0xFFFF, and clear on reset.
REQ-032 Without HAZARD_STATS_EN, neither port nor its logic SHALL exist.

Structure
REQ-033 Package cpu_pkg SHALL hold fwd_sel_t (FWD_REG, FWD_MEM, FWD_WB), the constant XZR = 31, and the slot struct type.
REQ-034 A sub-module pipe_slot (one resettable slot register with a bubble input) SHALL be instantiated three times.

Verification
REQ-035 SHALL test an EX-to-ID dependency: ADD X1 in EX (RegWrite), ID Rn=1 -> forwardA=01 next cycle, stall=0.
REQ-036 SHALL test a MEM-to-ID dependency: X2 producer in MEM, nothing in EX, ID Rm=2 with uses_Rm=1 -> forwardB=10.
REQ-037 SHALL test load-use: LDUR X3 in EX, ID Rn=3 -> stall=1 for exactly one cycle, then forwardA=10.
REQ-038 SHALL test XZR and priority: writes to X31 -> forwards 00; X5 written by both EX and MEM -> 01.
REQ-039 SHALL test flags and flush together: SUBS in EX, B.cond in ID -> one-cycle stall; br_taken=1 during that stall -> flush=1, stall=0, forwards 00.
REQ-040 SHALL test reset during a stall -> slots invalid, stall=0 next cycle, counters (when HAZARD_STATS_EN) = 0.
